// File: rtl/bram_sd_seq.sv
// bram_sd_seq: walks the 512-byte sectors of one save slot between cartridge
// BRAM and the HPS SD sector interface, one sd_rd/sd_wr strobe per sector.
// Tracks BRAM dirtiness and aborts cleanly when a new ROM download starts.
// Optional feature: define BKSEQ_AUTOSAVE_EN to let autosave_req start a save
// of dirty BRAM while idle.
module bram_sd_seq #(
  parameter int SECTOR_BITS = 7,
  parameter int SLOT_BITS   = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 download,
  input  logic                 img_mounted,
  input  logic                 img_readonly,
  input  logic                 img_size_nz,
  input  logic                 load_req,
  input  logic                 save_req,
  input  logic [SLOT_BITS-1:0] slot,
  input  logic                 sd_ack,
  input  logic                 bram_wr,
  input  logic                 autosave_req,
  output logic [31:0]          sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  output logic                 bk_ena,
  output logic                 busy,
  output logic                 loading,
  output logic                 dirty,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SAVE} state_t;

  state_t      state_q, state_d;
  logic [31:0] lba_q, lba_d;
  logic        rd_q, rd_d, wr_q, wr_d;
  logic        loading_q, loading_d;
  logic        dirty_q, dirty_d;
  logic        sticky_q, sticky_d;   // bram_wr seen since the current save was accepted
  logic        done_q, done_d;
  logic        bk_q, bk_d;

  logic        load_s1_q, load_s2_q, save_s1_q, save_s2_q;
  logic        ack_s1_q, ack_s2_q, dl_q;
  logic        load_rise, save_rise, ack_rise, ack_fall, dl_rise, bk_set;
  logic [31:0] lba_base;

  assign load_rise = load_s1_q & ~load_s2_q;
  assign save_rise = save_s1_q & ~save_s2_q;
  assign ack_rise  = ack_s1_q & ~ack_s2_q;
  assign ack_fall  = ~ack_s1_q & ack_s2_q;
  assign dl_rise   = download & ~dl_q;
  assign bk_set    = download & img_mounted & img_size_nz & ~img_readonly;

  // First sector of the selected slot; the low sector field starts at zero.
  assign lba_base  = {{(32-SLOT_BITS-SECTOR_BITS){1'b0}}, slot, {SECTOR_BITS{1'b0}}};

`ifdef BKSEQ_AUTOSAVE_EN
  logic auto_s1_q, auto_s2_q, auto_rise;
  assign auto_rise = auto_s1_q & ~auto_s2_q;

  // Autosave trigger edge detector.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      auto_s1_q <= 1'b0;
      auto_s2_q <= 1'b0;
    end else begin
      auto_s1_q <= autosave_req;
      auto_s2_q <= auto_s1_q;
    end
  end
`else
  logic unused_autosave;
  assign unused_autosave = autosave_req;
`endif

  // Register request/ack levels once and keep the previous sample for edge detection.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      load_s1_q <= 1'b0;
      load_s2_q <= 1'b0;
      save_s1_q <= 1'b0;
      save_s2_q <= 1'b0;
      ack_s1_q  <= 1'b0;
      ack_s2_q  <= 1'b0;
      dl_q      <= 1'b0;
    end else begin
      load_s1_q <= load_req;
      load_s2_q <= load_s1_q;
      save_s1_q <= save_req;
      save_s2_q <= save_s1_q;
      ack_s1_q  <= sd_ack;
      ack_s2_q  <= ack_s1_q;
      dl_q      <= download;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      lba_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      loading_q <= 1'b0;
      dirty_q   <= 1'b0;
      sticky_q  <= 1'b0;
      done_q    <= 1'b0;
      bk_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lba_q     <= lba_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      loading_q <= loading_d;
      dirty_q   <= dirty_d;
      sticky_q  <= sticky_d;
      done_q    <= done_d;
      bk_q      <= bk_d;
    end
  end

  // Next-state: image enable, dirty tracking and the sector walk.
  always_comb begin
    state_d   = state_q;
    lba_d     = lba_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    loading_d = loading_q;
    dirty_d   = dirty_q;
    sticky_d  = sticky_q;
    done_d    = 1'b0;
    bk_d      = bk_q;

    // A mount in the same cycle as the download edge keeps the image enabled.
    if (bk_set)       bk_d = 1'b1;
    else if (dl_rise) bk_d = 1'b0;

    // During LOAD the BRAM writes are the image itself, not user changes.
    if (bram_wr && state_q != S_LOAD) dirty_d = 1'b1;
    if (bram_wr && state_q == S_SAVE) sticky_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bk_q && load_rise) begin
          state_d   = S_LOAD;
          lba_d     = lba_base;
          rd_d      = 1'b1;
          loading_d = 1'b1;
        end else if (bk_q && save_rise) begin
          state_d   = S_SAVE;
          lba_d     = lba_base;
          wr_d      = 1'b1;
          sticky_d  = 1'b0;
        end
`ifdef BKSEQ_AUTOSAVE_EN
        else if (bk_q && dirty_q && auto_rise) begin
          state_d   = S_SAVE;
          lba_d     = lba_base;
          wr_d      = 1'b1;
          sticky_d  = 1'b0;
        end
`endif
      end
      S_LOAD, S_SAVE: begin
        if (dl_rise) begin
          // New ROM: drop the transfer; BRAM contents no longer match anything.
          state_d   = S_IDLE;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          loading_d = 1'b0;
          dirty_d   = 1'b0;
          sticky_d  = 1'b0;
        end else if (ack_rise) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
        end else if (ack_fall) begin
          if (&lba_q[SECTOR_BITS-1:0]) begin
            state_d   = S_IDLE;
            loading_d = 1'b0;
            done_d    = 1'b1;
            dirty_d   = (state_q == S_SAVE) ? (sticky_q | bram_wr) : 1'b0;
          end else begin
            lba_d = lba_q + 32'd1;
            rd_d  = (state_q == S_LOAD);
            wr_d  = (state_q == S_SAVE);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sd_lba  = lba_q;
  assign sd_rd   = rd_q;
  assign sd_wr   = wr_q;
  assign bk_ena  = bk_q;
  assign busy    = (state_q != S_IDLE);
  assign loading = loading_q;
  assign dirty   = dirty_q;
  assign done    = done_q;

endmodule
